// File: rtl/rx_frame_loader_if.sv
// Byte-receiver input and frame-buffer/status output bundle of rx_frame_loader.
// master = the loader, slave = the byte source plus frame-buffer/pipeline side.
interface rx_frame_loader_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              rx_pronto;
    logic [7:0]        rx_dados;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic [7:0]        frame_w;
    logic [7:0]        frame_h;
    logic              frame_valid;
    logic              frame_err;
    logic              busy;
    logic [3:0]        db_estado;

    modport master (
        input  rx_pronto, rx_dados,
        output mem_we, mem_addr, mem_data, frame_w, frame_h,
               frame_valid, frame_err, busy, db_estado
    );

    modport slave (
        output rx_pronto, rx_dados,
        input  mem_we, mem_addr, mem_data, frame_w, frame_h,
               frame_valid, frame_err, busy, db_estado
    );
endinterface

// File: rtl/rx_frame_loader.sv
// Parses sync/width/height/pixels/checksum packets from the serial receiver,
// writes pixels in raster order into the frame buffer and flags frame done/error.
module rx_frame_loader #(
    parameter int unsigned ADDR_W      = 14,
    parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
    parameter int unsigned TIMEOUT_CYC = 8680
) (
    input  logic                clock,
    input  logic                reset,
    rx_frame_loader_if.master   bus
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned AREA_W = (CNT_W > 16) ? CNT_W + 1 : 17;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_LARG = 4'd1,
        S_ALT  = 4'd2,
        S_PIX  = 4'd3,
        S_CHK  = 4'd4,
        S_OK   = 4'd5,
        S_ERR  = 4'd6
    } state_e;

    state_e            state_q;
    logic [7:0]        w_q;
    logic [CNT_W-1:0]  total_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        xor_q;
    logic [TMR_W-1:0]  tmr_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_data_q;
    logic [7:0]        frame_w_q;
    logic [7:0]        frame_h_q;
    logic              frame_valid_q;
    logic              frame_err_q;

    logic [AREA_W-1:0] area_c;
    logic              hdr_bad_c;
    logic              timeout_c;
    logic              last_pix_c;
    logic              in_frame_c;

    // Header area is computed wide enough that 255*255 never wraps before the limit check.
    assign area_c     = AREA_W'(w_q) * AREA_W'(bus.rx_dados);
    assign hdr_bad_c  = (bus.rx_dados == 8'd0) || (area_c > (AREA_W'(1) << ADDR_W));
    assign timeout_c  = (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
    assign last_pix_c = (cnt_q == total_q - CNT_W'(1));
    assign in_frame_c = (state_q == S_LARG) || (state_q == S_ALT) ||
                        (state_q == S_PIX)  || (state_q == S_CHK);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            w_q           <= '0;
            total_q       <= '0;
            cnt_q         <= '0;
            xor_q         <= '0;
            tmr_q         <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
            frame_w_q     <= '0;
            frame_h_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            mem_we_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;

            // Inter-byte watchdog: only runs inside a frame, any byte restarts it.
            if (in_frame_c && !bus.rx_pronto && !timeout_c) begin
                tmr_q <= tmr_q + TMR_W'(1);
            end else begin
                tmr_q <= '0;
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.rx_pronto && (bus.rx_dados == SYNC_BYTE)) begin
                        state_q <= S_LARG;
                    end
                end

                S_LARG: begin
                    if (bus.rx_pronto) begin
                        w_q <= bus.rx_dados;
                        if (bus.rx_dados == 8'd0) begin
                            state_q     <= S_ERR;
                            frame_err_q <= 1'b1;
                        end else begin
                            state_q <= S_ALT;
                        end
                    end else if (timeout_c) begin
                        state_q     <= S_ERR;
                        frame_err_q <= 1'b1;
                    end
                end

                S_ALT: begin
                    if (bus.rx_pronto) begin
                        if (hdr_bad_c) begin
                            state_q     <= S_ERR;
                            frame_err_q <= 1'b1;
                        end else begin
                            frame_w_q <= w_q;
                            frame_h_q <= bus.rx_dados;
                            total_q   <= CNT_W'(area_c);
                            cnt_q     <= '0;
                            xor_q     <= '0;
                            state_q   <= S_PIX;
                        end
                    end else if (timeout_c) begin
                        state_q     <= S_ERR;
                        frame_err_q <= 1'b1;
                    end
                end

                S_PIX: begin
                    if (bus.rx_pronto) begin
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= ADDR_W'(cnt_q);
                        mem_data_q <= bus.rx_dados;
                        xor_q      <= xor_q ^ bus.rx_dados;
                        cnt_q      <= cnt_q + CNT_W'(1);
                        if (last_pix_c) begin
                            state_q <= S_CHK;
                        end
                    end else if (timeout_c) begin
                        state_q     <= S_ERR;
                        frame_err_q <= 1'b1;
                    end
                end

                S_CHK: begin
                    if (bus.rx_pronto) begin
                        if (bus.rx_dados == xor_q) begin
                            state_q       <= S_OK;
                            frame_valid_q <= 1'b1;
                        end else begin
                            state_q     <= S_ERR;
                            frame_err_q <= 1'b1;
                        end
                    end else if (timeout_c) begin
                        state_q     <= S_ERR;
                        frame_err_q <= 1'b1;
                    end
                end

                S_OK:    state_q <= S_IDLE;
                S_ERR:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_data    = mem_data_q;
    assign bus.frame_w     = frame_w_q;
    assign bus.frame_h     = frame_h_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.db_estado   = state_q;

endmodule

// File: tb/tb_rx_frame_loader.sv
// Scoreboard bench for rx_frame_loader: expected pixel writes are queued as bytes
// are driven and matched (address, data, cycle) as the frame-buffer writes appear.
module tb_rx_frame_loader;

    localparam int unsigned ADDR_W      = 14;
    localparam int unsigned TIMEOUT_CYC = 8680;
    localparam logic [7:0]  SYNC        = 8'hAA;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    rx_frame_loader_if #(.ADDR_W(ADDR_W)) bus ();

    rx_frame_loader #(
        .ADDR_W     (ADDR_W),
        .SYNC_BYTE  (SYNC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        int                cyc;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] px[$];
    int         cyc        = 0;
    int         n_cmp      = 0;
    int         n_bad      = 0;
    int         valid_cnt  = 0;
    int         err_cnt    = 0;
    int         err_cyc    = 0;
    int         last_drive = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pop one expected write per observed mem_we cycle; a wide pulse shows up as an extra write.
    always @(negedge clk) begin
        wr_t e;
        if (bus.mem_we) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%02h cyc=%0d, required no write",
                         bus.mem_addr, bus.mem_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus.mem_addr !== e.addr || bus.mem_data !== e.data || cyc !== e.cyc) begin
                    n_bad++;
                    $display("FAIL write: got addr=%0d data=%02h cyc=%0d, required addr=%0d data=%02h cyc=%0d",
                             bus.mem_addr, bus.mem_data, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
        if (bus.frame_valid === 1'b1) valid_cnt++;
        if (bus.frame_err === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b, input bit pix, input int addr, input int gap);
        @(negedge clk);
        last_drive = cyc;
        if (pix) exp_q.push_back('{ADDR_W'(addr), b, cyc + 1});
        bus.rx_pronto = 1'b1;
        bus.rx_dados  = b;
        @(negedge clk);
        bus.rx_pronto = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] w, input logic [7:0] h, input logic [7:0] ck);
        send_byte(SYNC, 1'b0, 0, 1);
        send_byte(w, 1'b0, 0, 0);
        send_byte(h, 1'b0, 0, 2);
        for (int i = 0; i < px.size(); i++) send_byte(px[i], 1'b1, i, i % 2);
        send_byte(ck, 1'b0, 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_data, bus.frame_w, bus.frame_h,
             bus.frame_valid, bus.frame_err, bus.busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got we=%b addr=%0d data=%02h w=%0d h=%0d v=%b e=%b busy=%b, required all 0",
                     bus.mem_we, bus.mem_addr, bus.mem_data, bus.frame_w, bus.frame_h,
                     bus.frame_valid, bus.frame_err, bus.busy);
        end
        n_cmp++;
        if (bus.db_estado !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %0d, required 0", bus.db_estado);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nominal;
        int v0 = valid_cnt;
        int e0 = err_cnt;
        px.delete();
        px.push_back(8'h10); px.push_back(8'h20); px.push_back(8'h30); px.push_back(8'h40);
        send_frame(8'd2, 8'd2, 8'h40);
        n_cmp++;
        if (valid_cnt - v0 !== 1) begin
            n_bad++; $display("FAIL nominal_valid: got %0d pulses, required 1", valid_cnt - v0);
        end
        n_cmp++;
        if (err_cnt - e0 !== 0) begin
            n_bad++; $display("FAIL nominal_err: got %0d pulses, required 0", err_cnt - e0);
        end
        n_cmp++;
        if (bus.frame_w !== 8'd2 || bus.frame_h !== 8'd2) begin
            n_bad++; $display("FAIL nominal_dims: got %0dx%0d, required 2x2", bus.frame_w, bus.frame_h);
        end
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.db_estado !== 4'd0) begin
            n_bad++; $display("FAIL nominal_idle: got busy=%b state=%0d, required 0/0", bus.busy, bus.db_estado);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++; $display("FAIL nominal_writes: got %0d writes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_bad_checksum;
        int v0 = valid_cnt;
        int e0 = err_cnt;
        px.delete();
        px.push_back(8'h10); px.push_back(8'h20); px.push_back(8'h30); px.push_back(8'h40);
        send_frame(8'd2, 8'd2, 8'h41);
        n_cmp++;
        if (err_cnt - e0 !== 1 || valid_cnt - v0 !== 0) begin
            n_bad++; $display("FAIL badck_pulses: got err=%0d valid=%0d, required err=1 valid=0",
                              err_cnt - e0, valid_cnt - v0);
        end
        n_cmp++;
        if (bus.db_estado !== 4'd0 || exp_q.size() !== 0) begin
            n_bad++; $display("FAIL badck_end: got state=%0d missing_writes=%0d, required 0/0",
                              bus.db_estado, exp_q.size());
        end
    endtask

    task automatic test_header_errors;
        int e0 = err_cnt;
        send_byte(SYNC, 1'b0, 0, 1);
        send_byte(8'h00, 1'b0, 0, 3);
        n_cmp++;
        if (err_cnt - e0 !== 1) begin
            n_bad++; $display("FAIL hdr_w0_err: got %0d pulses, required 1", err_cnt - e0);
        end
        e0 = err_cnt;
        send_byte(SYNC, 1'b0, 0, 1);
        send_byte(8'h05, 1'b0, 0, 1);
        send_byte(8'h00, 1'b0, 0, 3);
        n_cmp++;
        if (err_cnt - e0 !== 1) begin
            n_bad++; $display("FAIL hdr_h0_err: got %0d pulses, required 1", err_cnt - e0);
        end
        e0 = err_cnt;
        send_byte(SYNC, 1'b0, 0, 1);
        send_byte(8'hFF, 1'b0, 0, 1);
        send_byte(8'hFF, 1'b0, 0, 3);
        n_cmp++;
        if (err_cnt - e0 !== 1) begin
            n_bad++; $display("FAIL hdr_big_err: got %0d pulses, required 1", err_cnt - e0);
        end
        n_cmp++;
        if (bus.frame_w !== 8'd2 || bus.frame_h !== 8'd2 || bus.db_estado !== 4'd0) begin
            n_bad++; $display("FAIL hdr_keep_dims: got %0dx%0d state=%0d, required 2x2 state=0",
                              bus.frame_w, bus.frame_h, bus.db_estado);
        end
    endtask

    task automatic test_timeout;
        int e0 = err_cnt;
        int v0 = valid_cnt;
        int k;
        send_byte(SYNC, 1'b0, 0, 1);
        send_byte(8'd2, 1'b0, 0, 1);
        send_byte(8'd2, 1'b0, 0, 1);
        send_byte(8'h10, 1'b1, 0, 0);
        k = last_drive;
        for (int i = 0; i < int'(TIMEOUT_CYC) + 50 && err_cnt == e0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (err_cnt - e0 !== 1 || valid_cnt - v0 !== 0) begin
            n_bad++; $display("FAIL timeout_pulse: got err=%0d valid=%0d, required err=1 valid=0",
                              err_cnt - e0, valid_cnt - v0);
        end
        n_cmp++;
        if (err_cyc !== k + 1 + int'(TIMEOUT_CYC)) begin
            n_bad++; $display("FAIL timeout_cycle: got err at cyc %0d, required %0d",
                              err_cyc, k + 1 + int'(TIMEOUT_CYC));
        end
        n_cmp++;
        if (exp_q.size() !== 0 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL timeout_end: got missing_writes=%0d busy=%b, required 0/0",
                              exp_q.size(), bus.busy);
        end
    endtask

    task automatic test_timeout_rescue;
        int e0 = err_cnt;
        int v0 = valid_cnt;
        int k;
        send_byte(SYNC, 1'b0, 0, 1);
        send_byte(8'd2, 1'b0, 0, 1);
        send_byte(8'd2, 1'b0, 0, 1);
        send_byte(8'h10, 1'b1, 0, 0);
        k = last_drive;
        // Next byte is consumed on the very edge the watchdog would expire.
        while (cyc < k + int'(TIMEOUT_CYC) - 1) @(negedge clk);
        send_byte(8'h20, 1'b1, 1, 0);
        send_byte(8'h30, 1'b1, 2, 0);
        send_byte(8'h40, 1'b1, 3, 0);
        send_byte(8'h40, 1'b0, 0, 3);
        n_cmp++;
        if (err_cnt - e0 !== 0 || valid_cnt - v0 !== 1) begin
            n_bad++; $display("FAIL rescue_pulses: got err=%0d valid=%0d, required err=0 valid=1",
                              err_cnt - e0, valid_cnt - v0);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++; $display("FAIL rescue_writes: got %0d missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_garbage_sync;
        logic [7:0] g [3] = '{8'h00, 8'h55, 8'hFF};
        int v0 = valid_cnt;
        int e0 = err_cnt;
        for (int i = 0; i < 3; i++) begin
            send_byte(g[i], 1'b0, 0, 0);
            n_cmp++;
            if (bus.busy !== 1'b0 || bus.db_estado !== 4'd0) begin
                n_bad++; $display("FAIL garbage_idle[%0d]: got busy=%b state=%0d, required 0/0",
                                  i, bus.busy, bus.db_estado);
            end
        end
        px.delete();
        px.push_back(8'h7E);
        send_frame(8'd1, 8'd1, 8'h7E);
        n_cmp++;
        if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 0 || bus.frame_w !== 8'd1 || bus.frame_h !== 8'd1) begin
            n_bad++; $display("FAIL one_px: got valid=%0d err=%0d dims=%0dx%0d, required 1/0 1x1",
                              valid_cnt - v0, err_cnt - e0, bus.frame_w, bus.frame_h);
        end
        v0 = valid_cnt;
        px.delete();
        px.push_back(SYNC);
        px.push_back(8'h55);
        send_frame(8'd1, 8'd2, 8'hFF);
        n_cmp++;
        if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 0 || bus.frame_h !== 8'd2) begin
            n_bad++; $display("FAIL sync_as_data: got valid=%0d err=%0d h=%0d, required 1/0 2",
                              valid_cnt - v0, err_cnt - e0, bus.frame_h);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++; $display("FAIL garbage_writes: got %0d missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame;
        int v0 = valid_cnt;
        int e0 = err_cnt;
        send_byte(SYNC, 1'b0, 0, 1);
        send_byte(8'd2, 1'b0, 0, 1);
        send_byte(8'd2, 1'b0, 0, 1);
        send_byte(8'h10, 1'b1, 0, 1);
        send_byte(8'h20, 1'b1, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.mem_we, bus.frame_valid, bus.frame_err, bus.busy} !== 4'b0 ||
            bus.db_estado !== 4'd0 || bus.frame_w !== 8'd0 || bus.mem_addr !== '0) begin
            n_bad++; $display("FAIL midrst_outputs: got we=%b v=%b e=%b busy=%b state=%0d w=%0d addr=%0d, required all 0",
                              bus.mem_we, bus.frame_valid, bus.frame_err, bus.busy,
                              bus.db_estado, bus.frame_w, bus.mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0 || exp_q.size() !== 0) begin
            n_bad++; $display("FAIL midrst_pulses: got valid=%0d err=%0d missing=%0d, required 0/0/0",
                              valid_cnt - v0, err_cnt - e0, exp_q.size());
        end
        px.delete();
        px.push_back(8'h10); px.push_back(8'h20); px.push_back(8'h30); px.push_back(8'h40);
        send_frame(8'd2, 8'd2, 8'h40);
        n_cmp++;
        if (valid_cnt - v0 !== 1 || bus.frame_w !== 8'd2 || exp_q.size() !== 0) begin
            n_bad++; $display("FAIL midrst_recover: got valid=%0d w=%0d missing=%0d, required 1/2/0",
                              valid_cnt - v0, bus.frame_w, exp_q.size());
        end
    endtask

    initial begin
        bus.rx_pronto = 1'b0;
        bus.rx_dados  = 8'h00;
        test_reset;
        test_nominal;
        test_bad_checksum;
        test_header_errors;
        test_timeout;
        test_timeout_rescue;
        test_garbage_sync;
        test_reset_mid_frame;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
